// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader for the instruction memory.
//
// Takes a byte stream over a valid/ready handshake:
//   [N lo][N hi] [4*N payload bytes, little-endian words] [XOR checksum].
// Each payload word is written to instruction memory at word address 0..N-1.
// The core stays stopped until the whole image has been written and the
// checksum byte matches.
//
// Ports:
//   i_clk           system clock, all logic on the rising edge
//   i_reset         synchronous, active-low reset
//   i_rx_valid      i_rx_data holds a byte
//   i_rx_data       stream byte
//   o_rx_ready      loader accepts a byte this cycle
//   o_imem_we       instruction-memory write strobe, one cycle per word
//   o_imem_addr     word address of the write
//   o_imem_wdata    word to write
//   o_core_run      core may execute (image loaded and checked)
//   o_load_done     image loaded and checksum matched (sticky)
//   o_load_error    header, checksum or timeout failure (sticky)
//   o_words_loaded  number of words written so far
module imem_loader #(
  parameter int ADDR_W      = 10,
  parameter int IMEM_DEPTH  = 1024,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  output logic              o_rx_ready,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_core_run,
  output logic              o_load_done,
  output logic              o_load_error,
  output logic [15:0]       o_words_loaded
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] IDLE_LIMIT = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_PAYLOAD,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_rx_ready;
  logic [15:0]       r_len;
  logic [15:0]       r_word_cnt;
  logic [1:0]        r_byte_idx;
  logic [23:0]       r_shift;
  logic [7:0]        r_csum;
  logic [CNT_W-1:0]  r_idle;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [15:0]       r_words_loaded;

  logic        w_accept;
  logic [15:0] w_hdr_len;
  logic        w_last_word;
  logic        w_counting;
  logic        w_timeout;

  assign w_accept    = i_rx_valid && r_rx_ready;
  assign w_hdr_len   = {i_rx_data, r_len[7:0]};
  assign w_last_word = (r_word_cnt == r_len - 16'd1);
  assign w_counting  = (r_state == S_HDR1) || (r_state == S_PAYLOAD) ||
                       (r_state == S_CHECK);
  // An accept in the same cycle always beats the timeout.
  assign w_timeout   = w_counting && !w_accept && (r_idle == IDLE_LIMIT);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HDR0: begin
        if (w_accept) w_next = S_HDR1;
      end
      S_HDR1: begin
        if (w_accept) begin
          if (17'(w_hdr_len) > 17'(IMEM_DEPTH)) w_next = S_ERROR;
          else if (w_hdr_len == 16'd0)          w_next = S_CHECK;
          else                                  w_next = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (w_accept && (r_byte_idx == 2'd3) && w_last_word) w_next = S_CHECK;
      end
      S_CHECK: begin
        if (w_accept) w_next = (i_rx_data == r_csum) ? S_DONE : S_ERROR;
      end
      default: w_next = r_state;
    endcase
    if (w_timeout) w_next = S_ERROR;
  end

  // NOTE: reset is synchronous, so it is tested inside the clocked block and
  // is not in the sensitivity list; sequential state uses non-blocking
  // assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state        <= S_HDR0;
      r_rx_ready     <= 1'b0;
      r_len          <= '0;
      r_word_cnt     <= '0;
      r_byte_idx     <= '0;
      r_shift        <= '0;
      r_csum         <= '0;
      r_idle         <= '0;
      r_we           <= 1'b0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_words_loaded <= '0;
    end else begin
      r_state    <= w_next;
      // Registered from the next state so ready stays low while reset is held
      // and never depends on rx_valid.
      r_rx_ready <= (w_next inside {S_HDR0, S_HDR1, S_PAYLOAD, S_CHECK});
      r_we       <= 1'b0;

      if (w_counting && !w_accept) r_idle <= r_idle + CNT_W'(1);
      else                         r_idle <= '0;

      if (w_accept) begin
        case (r_state)
          S_HDR0: r_len[7:0] <= i_rx_data;
          S_HDR1: begin
            r_len[15:8] <= i_rx_data;
            r_word_cnt  <= '0;
            r_byte_idx  <= '0;
            r_csum      <= '0;
          end
          S_PAYLOAD: begin
            r_csum     <= r_csum ^ i_rx_data;
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              // Lanes 0..2 sit in r_shift with lane 0 at the bottom.
              r_we           <= 1'b1;
              r_addr         <= r_word_cnt[ADDR_W-1:0];
              r_wdata        <= {i_rx_data, r_shift};
              r_word_cnt     <= r_word_cnt + 16'd1;
              r_words_loaded <= r_words_loaded + 16'd1;
            end else begin
              r_shift <= {i_rx_data, r_shift[23:8]};
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_rx_ready     = r_rx_ready;
  assign o_imem_we      = r_we;
  assign o_imem_addr    = r_addr;
  assign o_imem_wdata   = r_wdata;
  assign o_words_loaded = r_words_loaded;
  assign o_load_done    = (r_state == S_DONE);
  assign o_core_run     = (r_state == S_DONE);
  assign o_load_error   = (r_state == S_ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: self-checking bench for imem_loader.
// Directed and random byte streams are compared against a reference model
// that derives expected writes and final status from the stream format.
module tb_imem_loader;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;
  localparam int TMO    = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_run;
  logic              load_done;
  logic              load_error;
  logic [15:0]       words_loaded;

  always #5 clk = ~clk;

  imem_loader #(
    .ADDR_W     (ADDR_W),
    .IMEM_DEPTH (DEPTH),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_rx_valid    (rx_valid),
    .i_rx_data     (rx_data),
    .o_rx_ready    (rx_ready),
    .o_imem_we     (imem_we),
    .o_imem_addr   (imem_addr),
    .o_imem_wdata  (imem_wdata),
    .o_core_run    (core_run),
    .o_load_done   (load_done),
    .o_load_error  (load_error),
    .o_words_loaded(words_loaded)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  stream_q[$];
  int          gap_q[$];
  logic [31:0] exp_words[$];
  bit          exp_done;
  bit          exp_err;

  // Write log, filled only by the monitor.
  logic [ADDR_W-1:0] got_addr[$];
  logic [31:0]       got_data[$];
  logic [15:0]       got_cnt[$];
  int                we_while_done = 0;

  always @(negedge clk) begin
    if (imem_we) begin
      got_addr.push_back(imem_addr);
      got_data.push_back(imem_wdata);
      got_cnt.push_back(words_loaded);
      if (load_done) we_while_done++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Expected result from the stream rules: header length, little-endian
  // words, XOR checksum, and a cut at the first gap long enough to time out.
  task automatic model_run();
    int avail;
    int n;
    int words;
    bit tmo;
    logic [7:0] cs;
    exp_words.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    avail = stream_q.size();
    tmo   = 1'b0;
    for (int k = 1; k < stream_q.size(); k++) begin
      if (gap_q[k] >= TMO) begin
        avail = k;
        tmo   = 1'b1;
        break;
      end
    end
    if (avail < 2) begin
      exp_err = tmo;
      return;
    end
    n = int'(stream_q[0]) + 256 * int'(stream_q[1]);
    if (n > DEPTH) begin
      exp_err = 1'b1;
      return;
    end
    words = (avail - 2) / 4;
    if (words > n) words = n;
    for (int w = 0; w < words; w++)
      exp_words.push_back({stream_q[5+4*w], stream_q[4+4*w],
                           stream_q[3+4*w], stream_q[2+4*w]});
    if (avail > 2 + 4 * n) begin
      cs = 8'h00;
      for (int i = 2; i < 2 + 4 * n; i++) cs = cs ^ stream_q[i];
      exp_done = (stream_q[2+4*n] == cs);
      exp_err  = !exp_done;
    end else begin
      exp_err = tmo;
    end
  endtask

  task automatic zero_gaps();
    gap_q.delete();
    for (int i = 0; i < stream_q.size(); i++) gap_q.push_back(0);
  endtask

  task automatic build_image(input int n, input int max_gap, input bit corrupt);
    logic [7:0] b;
    logic [7:0] cs;
    logic [15:0] len;
    stream_q.delete();
    gap_q.delete();
    len = 16'(n);
    cs  = 8'h00;
    stream_q.push_back(len[7:0]);
    stream_q.push_back(len[15:8]);
    for (int i = 0; i < 4 * n; i++) begin
      b  = 8'($urandom);
      cs = cs ^ b;
      stream_q.push_back(b);
    end
    stream_q.push_back(corrupt ? (cs ^ 8'(1 + $urandom_range(254, 0))) : cs);
    for (int i = 0; i < stream_q.size(); i++)
      gap_q.push_back(int'($urandom_range(max_gap, 0)));
  endtask

  // Drives stream_q with gap_q idle cycles before each byte; stops early once
  // the loader drops ready. Returns at the falling edge after the last accept.
  task automatic send_stream();
    for (int i = 0; i < stream_q.size(); i++) begin
      repeat (gap_q[i]) begin
        @(negedge clk);
        rx_valid = 1'b0;
      end
      @(negedge clk);
      if (!rx_ready) begin
        rx_valid = 1'b0;
        break;
      end
      rx_valid = 1'b1;
      rx_data  = stream_q[i];
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    reset    = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    check({tag, "_rst_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_rst_we"},    32'(imem_we), 32'd0);
    check({tag, "_rst_addr"},  32'(imem_addr), 32'd0);
    check({tag, "_rst_wdata"}, imem_wdata, 32'd0);
    check({tag, "_rst_run"},   32'(core_run), 32'd0);
    check({tag, "_rst_done"},  32'(load_done), 32'd0);
    check({tag, "_rst_err"},   32'(load_error), 32'd0);
    check({tag, "_rst_words"}, 32'(words_loaded), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check({tag, "_ready_after_rst"}, 32'(rx_ready), 32'd1);
  endtask

  task automatic verify(input string tag, input int base);
    repeat (3) @(negedge clk);
    check({tag, "_nwrites"}, 32'(got_addr.size() - base), 32'(exp_words.size()));
    for (int i = 0; i < exp_words.size(); i++) begin
      if (base + i < got_addr.size()) begin
        check({tag, "_addr"},  32'(got_addr[base+i]), 32'(i));
        check({tag, "_wdata"}, got_data[base+i], exp_words[i]);
        check({tag, "_count"}, 32'(got_cnt[base+i]), 32'(i + 1));
      end
    end
    check({tag, "_done"},  32'(load_done), 32'(exp_done));
    check({tag, "_run"},   32'(core_run), 32'(exp_done));
    check({tag, "_err"},   32'(load_error), 32'(exp_err));
    check({tag, "_ready"}, 32'(rx_ready), 32'(!(exp_done || exp_err)));
    check({tag, "_words"}, 32'(words_loaded), 32'(exp_words.size()));
  endtask

  task automatic run_test(input string tag);
    int base;
    base = got_addr.size();
    model_run();
    send_stream();
    // Status must already be visible the cycle after the final accept.
    check({tag, "_done_timing"}, 32'(load_done), 32'(exp_done));
    check({tag, "_err_timing"},  32'(load_error), 32'(exp_err));
    verify(tag, base);
  endtask

  initial begin
    int b;

    // Two-word image. The XOR of the eight payload bytes is 0x90.
    apply_reset("dir_ok");
    stream_q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00,
                 8'h93, 8'h05, 8'hB0, 8'h00, 8'h90};
    zero_gaps();
    b = got_addr.size();
    run_test("dir_ok");
    if (got_data.size() >= b + 2) begin
      check("dir_ok_w0", got_data[b], 32'h00A00513);
      check("dir_ok_w1", got_data[b+1], 32'h00B00593);
    end else begin
      check("dir_ok_two_writes", 32'(got_data.size() - b), 32'd2);
    end

    // Same payload, wrong checksum: both words still written, then error.
    apply_reset("dir_badcs");
    stream_q[10] = 8'h29;
    run_test("dir_badcs");

    // N = 1025 exceeds the depth: error right after the header.
    apply_reset("hdr_big");
    stream_q = '{8'h01, 8'h04};
    zero_gaps();
    run_test("hdr_big");

    // Empty images.
    apply_reset("n0_ok");
    stream_q = '{8'h00, 8'h00, 8'h00};
    zero_gaps();
    run_test("n0_ok");
    apply_reset("n0_bad");
    stream_q = '{8'h00, 8'h00, 8'h5A};
    zero_gaps();
    run_test("n0_bad");

    // Long idle in HDR0 must not time out.
    apply_reset("hdr0_idle");
    repeat (100) @(negedge clk);
    check("hdr0_idle_err", 32'(load_error), 32'd0);
    check("hdr0_idle_ready", 32'(rx_ready), 32'd1);
    build_image(16, 7, 1'b0);
    run_test("hdr0_idle_load");

    // Random 16-word images with gaps up to 7.
    for (int it = 0; it < 3; it++) begin
      apply_reset("rand16");
      build_image(16, 7, 1'b0);
      gap_q[6] = TMO - 1;
      run_test("rand16");
    end

    // Random small images, checksum sometimes corrupted.
    for (int it = 0; it < 4; it++) begin
      apply_reset("rand_small");
      build_image(int'($urandom_range(6, 1)), 5, 1'($urandom_range(1, 0)));
      run_test("rand_small");
    end

    // A 9-cycle gap mid-payload times out.
    apply_reset("tmo9");
    build_image(6, 3, 1'b0);
    gap_q[11] = 9;
    run_test("tmo9");

    // A gap of exactly TIMEOUT_CYC also times out.
    apply_reset("tmo8");
    build_image(3, 2, 1'b0);
    gap_q[13] = TMO;
    run_test("tmo8");

    // Reset mid-load after three bytes of word 3: no write of word 3.
    apply_reset("midrst");
    build_image(5, 2, 1'b0);
    while (stream_q.size() > 17) void'(stream_q.pop_back());
    while (gap_q.size() > 17) void'(gap_q.pop_back());
    b = got_addr.size();
    model_run();
    send_stream();
    repeat (2) @(negedge clk);
    check("midrst_writes_before", 32'(got_addr.size() - b), 32'd3);
    apply_reset("midrst");
    repeat (3) @(negedge clk);
    check("midrst_writes_after", 32'(got_addr.size() - b), 32'd3);

    // A fresh stream after the mid-load reset loads from address 0.
    build_image(4, 2, 1'b0);
    run_test("after_rst");

    check("we_while_done", 32'(we_while_done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
